// File: rtl/wb_arb_pkg.sv
// Shared widths, the register-zero index and the types used by the write-port arbiter.
package wb_arb_pkg;

  localparam int WIDTH    = 64;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 31;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } wb_req_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/mux2.sv
// Plain 2:1 data mux; sel=1 picks b_i.
module mux2 #(
  parameter int W = 64
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sel_i,
  output logic [W-1:0] y_o
);

  assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU (req0)
// and load (req1) producers, feeding a one-entry write stage that holds under wr_stall.
module wb_port_arbiter
  import wb_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [WIDTH-1:0]  req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [WIDTH-1:0]  req1_data,
  output logic              req1_ready,
  output logic              mux_sel,
  input  logic              wr_stall,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              busy
);

  // Handshake: a producer transfers in a cycle where its valid and ready are both high;
  // a producer seeing ready=0 keeps valid, addr and data unchanged until it is accepted.

  wb_state_e         state_q;
  wb_req_t           stage_q;
  logic              last_grant_q;

  logic              accept;
  logic              gnt_vld;
  logic              gnt_idx;
  logic [ADDR_W-1:0] mux_addr;
  logic [WIDTH-1:0]  mux_data;

  assign busy   = (state_q == FULL);
  assign accept = !busy || !wr_stall;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = last_grant_q;
    if (accept) begin
      if (req0_valid && req1_valid) begin
        gnt_vld = 1'b1;
        gnt_idx = ~last_grant_q;
      end else if (req0_valid) begin
        gnt_vld = 1'b1;
        gnt_idx = 1'b0;
      end else if (req1_valid) begin
        gnt_vld = 1'b1;
        gnt_idx = 1'b1;
      end
    end
  end

  // With no grant the select parks on the previous winner.
  assign mux_sel    = gnt_idx;
  assign req0_ready = gnt_vld && (gnt_idx == 1'b0);
  assign req1_ready = gnt_vld && (gnt_idx == 1'b1);

  assign mux_addr = mux_sel ? req1_addr : req0_addr;

  mux2 #(.W(WIDTH)) u_data_mux (
    .a_i  (req0_data),
    .b_i  (req1_data),
    .sel_i(mux_sel),
    .y_o  (mux_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= EMPTY;
      stage_q      <= '0;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (gnt_vld) begin
            state_q      <= FULL;
            stage_q      <= '{addr: mux_addr, data: mux_data};
            last_grant_q <= gnt_idx;
          end
        end
        FULL: begin
          // Retire and refill at the same edge so back-to-back writes have no bubble.
          if (!wr_stall) begin
            if (gnt_vld) begin
              stage_q      <= '{addr: mux_addr, data: mux_data};
              last_grant_q <= gnt_idx;
            end else begin
              state_q <= EMPTY;
            end
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign wr_addr = stage_q.addr;
  assign wr_data = stage_q.data;
  assign wr_en   = busy && !wr_stall && (stage_q.addr != ADDR_W'(ZERO_REG));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: per-scenario tasks plus a write-port scoreboard.
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  localparam int EXP_W = ADDR_W + WIDTH;

  logic              clk;
  logic              reset_n;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [WIDTH-1:0]  req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [WIDTH-1:0]  req1_data;
  logic              req1_ready;
  logic              mux_sel;
  logic              wr_stall;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              busy;

  logic [EXP_W-1:0] exp_q[$];
  int               n_checks;
  int               n_fail;
  logic             exp_last;

  wb_port_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req0_valid(req0_valid),
    .req0_addr (req0_addr),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_addr (req1_addr),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .mux_sel   (mux_sel),
    .wr_stall  (wr_stall),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // scoreboard: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    logic [EXP_W-1:0] exp_w;
    if (reset_n && wr_en) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: actual addr=%0d data=%h required=no write", wr_addr, wr_data);
      end else begin
        exp_w = exp_q.pop_front();
        if ({wr_addr, wr_data} !== exp_w) begin
          n_fail++;
          $display("FAIL wr_port: actual addr=%0d data=%h required addr=%0d data=%h",
                   wr_addr, wr_data, exp_w[EXP_W-1 -: ADDR_W], exp_w[WIDTH-1:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    req0_valid = 1'b0;
    req0_addr  = '0;
    req0_data  = '0;
    req1_valid = 1'b0;
    req1_addr  = '0;
    req1_data  = '0;
    wr_stall   = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive_idle();
    exp_last = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({busy, wr_en, wr_addr, wr_data} !== {1'b0, 1'b0, {ADDR_W{1'b0}}, {WIDTH{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_values: actual busy=%b wr_en=%b addr=%0d data=%h required all zero",
               busy, wr_en, wr_addr, wr_data);
    end
    reset_n = 1'b1;
    tick();
    // load addr 3 and hold it with a stall
    req0_valid = 1'b1;
    req0_addr  = 5'd3;
    req0_data  = 64'h3333;
    wr_stall   = 1'b1;
    tick();
    req0_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || wr_addr !== 5'd3) begin
      n_fail++;
      $display("FAIL reset_prefill: actual busy=%b addr=%0d required busy=1 addr=3", busy, wr_addr);
    end
    #1 reset_n = 1'b0;
    wr_stall = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: actual busy=%b wr_en=%b required busy=0 wr_en=0", busy, wr_en);
    end
    #1 reset_n = 1'b1;
    exp_last = 1'b1;
    tick();
    req0_valid = 1'b1;
    req0_addr  = 5'd8;
    req0_data  = 64'h8;
    req1_valid = 1'b1;
    req1_addr  = 5'd9;
    req1_data  = 64'h9;
    @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready, mux_sel} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_first_grant: actual r0=%b r1=%b sel=%b required r0=1 r1=0 sel=0",
               req0_ready, req1_ready, mux_sel);
    end
    exp_q.push_back({5'd8, 64'h8});
    exp_last = 1'b0;
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready, mux_sel} !== 3'b011) begin
      n_fail++;
      $display("FAIL reset_second_grant: actual r0=%b r1=%b sel=%b required r0=0 r1=1 sel=1",
               req0_ready, req1_ready, mux_sel);
    end
    exp_q.push_back({5'd9, 64'h9});
    exp_last = 1'b1;
    tick();
    drive_idle();
    tick();
    tick();
  endtask

  task automatic test_contention();
    int  i0;
    int  i1;
    int  cyc;
    logic exp_g;
    i0  = 0;
    i1  = 0;
    cyc = 0;
    while ((i0 < 4 || i1 < 4) && cyc < 20) begin
      req0_valid = (i0 < 4);
      req0_addr  = ADDR_W'(i0 + 1);
      req0_data  = 64'hA0 + 64'(i0);
      req1_valid = (i1 < 4);
      req1_addr  = ADDR_W'(i1 + 11);
      req1_data  = 64'hB0 + 64'(i1);
      @(negedge clk);
      if (req0_valid && req1_valid) exp_g = ~exp_last;
      else if (req0_valid)          exp_g = 1'b0;
      else                          exp_g = 1'b1;
      n_checks++;
      if (req0_ready !== !exp_g || req1_ready !== exp_g || mux_sel !== exp_g) begin
        n_fail++;
        $display("FAIL contention_grant cyc %0d: actual r0=%b r1=%b sel=%b required grant=%0d",
                 cyc, req0_ready, req1_ready, mux_sel, exp_g);
      end
      if (exp_g) begin
        exp_q.push_back({req1_addr, req1_data});
        i1++;
      end else begin
        exp_q.push_back({req0_addr, req0_data});
        i0++;
      end
      exp_last = exp_g;
      cyc++;
      tick();
    end
    drive_idle();
    tick();
    tick();
  endtask

  task automatic test_single();
    req0_valid = 1'b1;
    req0_addr  = 5'd5;
    req0_data  = 64'hDEAD_BEEF;
    @(negedge clk);
    n_checks++;
    if (req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready: actual %b required 1", req0_ready);
    end
    exp_q.push_back({5'd5, 64'hDEAD_BEEF});
    exp_last = 1'b0;
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 64'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL single_write: actual en=%b addr=%0d data=%h required en=1 addr=5 data=deadbeef",
               wr_en, wr_addr, wr_data);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy_drop: actual %b required 0", busy);
    end
    tick();
  endtask

  task automatic test_stall();
    req0_valid = 1'b1;
    req0_addr  = 5'd7;
    req0_data  = 64'h7777;
    @(negedge clk);
    exp_q.push_back({5'd7, 64'h7777});
    exp_last = 1'b0;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_addr  = 5'd20;
    req1_data  = 64'h2020;
    wr_stall   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({req0_ready, req1_ready, wr_en, busy} !== 4'b0001 || wr_addr !== 5'd7 ||
          wr_data !== 64'h7777) begin
        n_fail++;
        $display("FAIL stall_hold %0d: actual r0=%b r1=%b en=%b busy=%b addr=%0d data=%h required 0/0/0/1 addr=7 data=7777",
                 k, req0_ready, req1_ready, wr_en, busy, wr_addr, wr_data);
      end
      tick();
    end
    wr_stall = 1'b0;
    @(negedge clk);
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd7 || req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: actual en=%b addr=%0d r1=%b required en=1 addr=7 r1=1",
               wr_en, wr_addr, req1_ready);
    end
    exp_q.push_back({5'd20, 64'h2020});
    exp_last = 1'b1;
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd20) begin
      n_fail++;
      $display("FAIL stall_refill: actual en=%b addr=%0d required en=1 addr=20", wr_en, wr_addr);
    end
    tick();
    drive_idle();
    tick();
  endtask

  task automatic test_zero_reg();
    req1_valid = 1'b1;
    req1_addr  = 5'd31;
    req1_data  = 64'h1;
    @(negedge clk);
    n_checks++;
    if (req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_ready: actual %b required 1", req1_ready);
    end
    exp_last = 1'b1;
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || wr_en !== 1'b0 || wr_addr !== 5'd31) begin
      n_fail++;
      $display("FAIL zero_squash: actual busy=%b en=%b addr=%0d required busy=1 en=0 addr=31",
               busy, wr_en, wr_addr);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_retire: actual busy=%b required 0", busy);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      req0_valid = 1'b1;
      req0_addr  = ADDR_W'(i + 1);
      req0_data  = {$urandom, $urandom};
      @(negedge clk);
      n_checks++;
      if (req0_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready %0d: actual %b required 1", i, req0_ready);
      end
      if (wr_en === 1'b1) pulses++;
      exp_q.push_back({req0_addr, req0_data});
      exp_last = 1'b0;
      tick();
    end
    req0_valid = 1'b0;
    @(negedge clk);
    if (wr_en === 1'b1) pulses++;
    tick();
    n_checks++;
    if (pulses !== 8) begin
      n_fail++;
      $display("FAIL b2b_pulses: actual %0d required 8", pulses);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: actual busy=%b en=%b required 0/0", busy, wr_en);
    end
    tick();
  endtask

  // final report
  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_contention();
    test_single();
    test_stall();
    test_zero_reg();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: actual %0d writes outstanding required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
